// File: rtl/pipe_skid_stage_pkg.sv
// Purpose: shared occupancy/state encodings for the elastic pipeline stage.
// Latency: n/a (types and helpers only).
// Backpressure: n/a; accepts() defines when a stage may take a new entry.
package pipe_skid_stage_pkg;

  // The state value is also the number of entries held, so it drives
  // the occupancy port directly.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 8;

  // A stage can take a new entry unless both main and skid are occupied.
  function automatic logic accepts(input occ_state_e st);
    return st != ST_FULL;
  endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Purpose: enable-loaded {ctrl,data} holding register, used as main and skid slot.
// Latency: 1 cycle from ld to q.
// Backpressure: none; the parent decides when to load.
// Ports: CLK/RST_N clock and async active-low clear; ld loads d_ctrl/d_data;
//        clr_ctrl zeroes only the ctrl field (data keeps its value); q_* outputs.
module pipe_payload_reg
  import pipe_skid_stage_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ld,
  input  logic              clr_ctrl,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_ctrl <= '0;
      q_data <= '0;
    end else begin
      // clr_ctrl and ld are never asserted together by the parent; clear wins.
      if (clr_ctrl)
        q_ctrl <= '0;
      else if (ld)
        q_ctrl <= d_ctrl;
      if (ld)
        q_data <= d_data;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Purpose: elastic pipeline-stage register with a 2-entry skid buffer and flush.
// Latency: 1 cycle in->out; 1 entry/cycle sustained with out_ready high.
// Backpressure: in_ready is a pure register decode (low only when FULL), so
//               out_ready never reaches in_ready combinationally.
// Ports: CLK, RST_N (async active-low); in_valid/in_ready/in_ctrl/in_data upstream;
//        flush kills held and incoming entries; out_valid/out_ready/out_ctrl/out_data
//        downstream; occupancy = entries held (0..2).
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int DATA_W           = DEF_DATA_W,
  parameter int CTRL_W           = DEF_CTRL_W,
  parameter bit ZERO_CTRL_BUBBLE = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  occ_state_e        state_q;
  occ_state_e        state_d;
  logic              in_xfer;
  logic              out_xfer;
  logic              main_ld;
  logic              main_from_skid;
  logic              main_clr_ctrl;
  logic              skid_ld;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic [DATA_W-1:0] main_d_data;
  logic [CTRL_W-1:0] skid_q_ctrl;
  logic [DATA_W-1:0] skid_q_data;

  // Validity of main and skid lives entirely in state_q; the payload
  // registers carry no valid bits of their own.
  assign in_ready  = accepts(state_q);
  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = state_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      state_q <= ST_EMPTY;
    else
      state_q <= state_d;
  end

  // Next-state decode; flush overrides every transfer
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_xfer) state_d = ST_ONE;
        ST_ONE: begin
          if (in_xfer && !out_xfer)
            state_d = ST_FULL;
          else if (!in_xfer && out_xfer)
            state_d = ST_EMPTY;
        end
        ST_FULL:  if (out_xfer) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Datapath controls
  always_comb begin
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    if (!flush) begin
      case (state_q)
        ST_EMPTY: main_ld = in_xfer;
        ST_ONE: begin
          main_ld = in_xfer & out_xfer;
          skid_ld = in_xfer & ~out_xfer;
        end
        ST_FULL: begin
          main_ld        = out_xfer;
          main_from_skid = 1'b1;
        end
        default: ;
      endcase
    end
    // Zeroing ctrl on entry to EMPTY makes a bubble look like a NOP downstream.
    main_clr_ctrl = ZERO_CTRL_BUBBLE && (state_d == ST_EMPTY);
  end

  assign main_d_ctrl = main_from_skid ? skid_q_ctrl : in_ctrl;
  assign main_d_data = main_from_skid ? skid_q_data : in_data;

  pipe_payload_reg #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) u_main (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .ld       (main_ld),
    .clr_ctrl (main_clr_ctrl),
    .d_ctrl   (main_d_ctrl),
    .d_data   (main_d_data),
    .q_ctrl   (out_ctrl),
    .q_data   (out_data)
  );

  // Skid contents are stale once state leaves FULL; they are never read then.
  pipe_payload_reg #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) u_skid (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .ld       (skid_ld),
    .clr_ctrl (1'b0),
    .d_ctrl   (in_ctrl),
    .d_data   (in_data),
    .q_ctrl   (skid_q_ctrl),
    .q_data   (skid_q_data)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

  typedef struct packed {
    logic [7:0]  c;
    logic [31:0] d;
  } ent_t;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        in_valid;
  logic [7:0]  in_ctrl;
  logic [31:0] in_data;
  logic        flush;
  logic        out_ready;

  logic        in_ready0, out_valid0;
  logic [7:0]  out_ctrl0;
  logic [31:0] out_data0;
  logic [1:0]  occupancy0;

  logic        in_ready1, out_valid1;
  logic [7:0]  out_ctrl1;
  logic [31:0] out_data1;
  logic [1:0]  occupancy1;

  int   checks = 0;
  int   errors = 0;
  ent_t sb[$];
  logic [7:0] last_ctrl1 = 8'h00;

  always #5 CLK = ~CLK;

  pipe_skid_stage #(.DATA_W(32), .CTRL_W(8), .ZERO_CTRL_BUBBLE(1'b1)) dut0 (
    .CLK(CLK), .RST_N(RST_N),
    .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0), .out_data(out_data0),
    .occupancy(occupancy0)
  );

  pipe_skid_stage #(.DATA_W(32), .CTRL_W(8), .ZERO_CTRL_BUBBLE(1'b0)) dut1 (
    .CLK(CLK), .RST_N(RST_N),
    .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1), .out_data(out_data1),
    .occupancy(occupancy1)
  );

  function automatic logic [7:0] ctrl_of(input logic [31:0] d);
    return {4'hC, d[3:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    in_valid = v;
    in_data  = d;
    in_ctrl  = ctrl_of(d);
  endtask

  // One clock cycle: check DUT state against the model at the negedge,
  // account for the transfers of this cycle, then move past the posedge.
  task automatic tick();
    logic in_x, out_x;
    int   n;
    ent_t e;
    @(negedge CLK);
    n = sb.size();
    chk("occupancy", 64'(occupancy0), 64'(n));
    chk("occupancy_b", 64'(occupancy1), 64'(n));
    chk("in_ready", 64'(in_ready0), 64'(n < 2));
    chk("out_valid", 64'(out_valid0), 64'(n != 0));
    chk("out_valid_b", 64'(out_valid1), 64'(n != 0));
    if (n == 0) begin
      chk("bubble_ctrl", 64'(out_ctrl0), 64'(0));
      chk("hold_ctrl", 64'(out_ctrl1), 64'(last_ctrl1));
    end else begin
      chk("main_ctrl_b", 64'(out_ctrl1), 64'(sb[0].c));
      last_ctrl1 = sb[0].c;
    end
    in_x  = in_valid && (n < 2);
    out_x = out_ready && (n != 0);
    if (out_x) begin
      e = sb.pop_front();
      chk("out_ctrl", 64'(out_ctrl0), 64'(e.c));
      chk("out_data", 64'(out_data0), 64'(e.d));
      chk("out_data_b", 64'(out_data1), 64'(e.d));
    end
    if (flush)
      sb.delete();
    else if (in_x)
      sb.push_back({in_ctrl, in_data});
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0;
    drive(1'b0, 32'h0);
    flush = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid0), 64'(0));
    chk("rst_out_ctrl", 64'(out_ctrl0), 64'(0));
    chk("rst_out_data", 64'(out_data0), 64'(0));
    chk("rst_in_ready", 64'(in_ready0), 64'(1));
    chk("rst_occupancy", 64'(occupancy0), 64'(0));
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    tick();

    // Streaming at full rate
    out_ready = 1'b1;
    drive(1'b1, 32'h11); tick();
    drive(1'b1, 32'h22); tick();
    drive(1'b1, 32'h33); tick();
    drive(1'b0, 32'h0);
    tick();
    tick();
    chk("hold_ctrl_after_drain", 64'(out_ctrl1), 64'(8'hC3));

    // Back-pressure fills the skid; C waits upstream
    out_ready = 1'b0;
    drive(1'b1, 32'hA); tick();
    drive(1'b1, 32'hB); tick();
    drive(1'b1, 32'hC); tick();
    tick();
    out_ready = 1'b1;
    tick();
    tick();
    drive(1'b0, 32'h0);
    tick();
    tick();

    // Flush in FULL with a valid input waiting
    out_ready = 1'b0;
    drive(1'b1, 32'hD); tick();
    drive(1'b1, 32'hE); tick();
    drive(1'b1, 32'hF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    tick();
    out_ready = 1'b1;
    tick();
    tick();

    // Flush coinciding with a delivery in ONE
    drive(1'b1, 32'h47); tick();
    drive(1'b0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();

    // Random soak
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      tick();
    end
    flush = 1'b0;
    drive(1'b0, 32'h0);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("soak_drained", 64'(sb.size()), 64'(0));

    // Asynchronous reset while full and an input is pending
    out_ready = 1'b0;
    drive(1'b1, 32'h5A); tick();
    drive(1'b1, 32'h6B); tick();
    drive(1'b1, 32'h7C);
    #2;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid0), 64'(0));
    chk("mid_rst_out_ctrl", 64'(out_ctrl0), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready0), 64'(1));
    chk("mid_rst_occupancy", 64'(occupancy0), 64'(0));
    chk("mid_rst_ctrl_b", 64'(out_ctrl1), 64'(0));
    sb.delete();
    last_ctrl1 = 8'h00;
    drive(1'b0, 32'h0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    tick();
    out_ready = 1'b1;
    drive(1'b1, 32'h99); tick();
    drive(1'b0, 32'h0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
